sample_block_packer: RTL

- Upstream stage of the statistics chain (mean, var).
- Accepts a stream of 8-bit samples with a valid/ready handshake.
- Assembles each group of N_VALUES = SIZE/8 consecutive samples into one SIZE-bit block; the block feeds the `values` / `input_valid` inputs of mean and var.
- Ping-pong (two-bank) buffered, so the input keeps streaming while a finished block waits for the consumer.

---
 rtl/stats_pkg.sv | 12 +
 rtl/sample_block_packer_bank.sv | 37 +++
 rtl/sample_block_packer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stats_pkg.sv
// Shared constants for the statistics chain (sample packer, mean, var).
package stats_pkg;
  localparam int SIZE_DEF          = 512;
  localparam int LOG2_N_VALUES_DEF = 6;
  localparam int BYTE_W            = 8;
  localparam int CNT_W             = 16;
  localparam int N_VALUES_DEF      = SIZE_DEF >> 3;

  function automatic int n_values(input int size);
    return size >> 3;
  endfunction
endpackage

// File: rtl/sample_block_packer_bank.sv
// One SIZE-bit block buffer with a single-byte write port; contents are never reset.
module block_bank
  import stats_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int IDX_W = LOG2_N_VALUES_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BYTE_W-1:0] data,
  output logic [SIZE-1:0]   bank
);
  localparam int NB = n_values(SIZE);

  logic [SIZE-1:0] bank_q;
  logic [SIZE-1:0] bank_d;

  // Next bank image: only the addressed byte changes on a write.
  always_comb begin
    bank_d = bank_q;
    for (int k = 0; k < NB; k++) begin
      if (we && (idx == IDX_W'(k))) begin
        bank_d[k*BYTE_W +: BYTE_W] = data;
      end else begin
        bank_d[k*BYTE_W +: BYTE_W] = bank_q[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Bank storage register.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign bank = bank_q;
endmodule

// File: rtl/sample_block_packer.sv
// Packs 8-bit samples into SIZE-bit blocks through two ping-pong banks so input
// keeps streaming while a finished block waits for the consumer.
module sample_block_packer
  import stats_pkg::*;
#(
  parameter int DEBUG         = 0,
  parameter int SIZE          = SIZE_DEF,
  parameter int LOG2_N_VALUES = LOG2_N_VALUES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [SIZE-1:0]   values,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  block_count,
  output logic [CNT_W-1:0]  discard_count
);
  localparam int N_VALUES = n_values(SIZE);
  localparam int IDX_W    = (LOG2_N_VALUES > 0) ? LOG2_N_VALUES : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VALUES - 1);

  // Trace output is a simulation aid and is not part of this synthesizable body.
  logic unused_debug;
  assign unused_debug = (DEBUG != 0);

  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] block_count_q, block_count_d;
  logic [CNT_W-1:0] discard_count_q, discard_count_d;

  logic             accept;
  logic             handshake;
  logic             last_byte;
  logic [IDX_W-1:0] wr_idx;
  logic [SIZE-1:0]  bank_data [2];

  assign in_ready      = ~full_q[wr_sel_q] & ~rst;
  assign out_valid     = full_q[rd_sel_q];
  assign values        = rd_sel_q ? bank_data[1] : bank_data[0];
  assign block_count   = block_count_q;
  assign discard_count = discard_count_q;

  // Handshake decode; a start-of-frame sample always lands in byte 0.
  always_comb begin
    accept    = in_valid & in_ready;
    handshake = full_q[rd_sel_q] & out_ready;
    wr_idx    = in_sof ? {IDX_W{1'b0}} : idx_q;
    last_byte = (wr_idx == LAST_IDX);
  end

  // Next-state for bank flags, pointers and counters; reset wins over everything.
  always_comb begin
    full_d          = full_q;
    wr_sel_d        = wr_sel_q;
    rd_sel_d        = rd_sel_q;
    idx_d           = idx_q;
    block_count_d   = block_count_q;
    discard_count_d = discard_count_q;
    if (rst) begin
      full_d          = 2'b00;
      wr_sel_d        = 1'b0;
      rd_sel_d        = 1'b0;
      idx_d           = {IDX_W{1'b0}};
      block_count_d   = {CNT_W{1'b0}};
      discard_count_d = {CNT_W{1'b0}};
    end else begin
      if (accept) begin
        if (in_sof && (idx_q != {IDX_W{1'b0}})) begin
          discard_count_d = discard_count_q + 16'd1;
        end else begin
          discard_count_d = discard_count_q;
        end
        if (last_byte) begin
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = ~wr_sel_q;
          idx_d            = {IDX_W{1'b0}};
          block_count_d    = block_count_q + 16'd1;
        end else begin
          idx_d = wr_idx + IDX_W'(1);
        end
      end else begin
        idx_d = idx_q;
      end
      // The write bank is never full while accepting, so this cannot collide.
      if (handshake) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        rd_sel_d = rd_sel_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    full_q          <= full_d;
    wr_sel_q        <= wr_sel_d;
    rd_sel_q        <= rd_sel_d;
    idx_q           <= idx_d;
    block_count_q   <= block_count_d;
    discard_count_q <= discard_count_d;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    block_bank #(
      .SIZE  (SIZE),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk  (clk),
      .we   (accept & (wr_sel_q == b[0])),
      .idx  (wr_idx),
      .data (in_data),
      .bank (bank_data[b])
    );
  end
endmodule
